// File: rtl/bcd_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_pkg
// Shared definitions for the cascaded modulo/BCD up/down counter chain.
//   digit_width(mod) : bits needed to hold one digit counting 0..mod-1
//                      (never less than 1).
//   DIR_UP/DIR_DOWN  : encoding of the 'up' direction input.
// -----------------------------------------------------------------------------
package bcd_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int digit_width(input int mod);
        return (mod <= 2) ? 1 : $clog2(mod);
    endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// -----------------------------------------------------------------------------
// mod_digit_cell
// One digit of the counter chain: a modulo-MOD up/down counter that loads,
// steps or holds. Load values at or above MOD are clamped to MOD-1.
//
// Ports:
//   clk   in      rising-edge clock
//   clr   in      synchronous active-low reset (digit -> 0)
//   step  in      advance one position in direction 'up' (wraps at the ends)
//   load  in      parallel load of d (takes priority over step)
//   up    in      direction, DIR_UP / DIR_DOWN
//   d     in  DW  load value
//   q     out DW  registered digit value
//   term  out     digit sits at its terminal value for the current direction
//                 (MOD-1 when counting up, 0 when counting down)
// -----------------------------------------------------------------------------
module mod_digit_cell
    import bcd_counter_pkg::*;
#(
    parameter int MOD = 10,
    parameter int DW  = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          step,
    input  logic          load,
    input  logic          up,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          term
);

    localparam logic [DW-1:0] MAX_VAL = DW'(MOD - 1);
    // One extra bit so MOD=2**DW (e.g. 16) is representable in the compare.
    localparam logic [DW:0]   MOD_EXT = (DW + 1)'(MOD);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] d_clamped;

    always_comb begin
        d_clamped = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
        q_d       = q_q;
        if (load) begin
            q_d = d_clamped;
        end else if (step) begin
            if (up == DIR_UP) begin
                q_d = (q_q == MAX_VAL) ? '0 : q_q + 1'b1;
            end else begin
                q_d = (q_q == '0) ? MAX_VAL : q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign term = (up == DIR_UP) ? (q_q == MAX_VAL) : (q_q == '0);

endmodule

// File: rtl/bcd_updown_counter_chain.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_chain
// DIGITS cascaded modulo-MOD up/down digits (BCD when MOD=10). Digit i steps
// only when every lower digit is terminal, so all digits move on the same
// edge without any binary carry between digit fields.
//
// Configuration:
//   BCD_CHAIN_SATURATE_EN  defined   -> a counting edge with Co=1 holds Q
//                                       (saturates) instead of wrapping.
//                          undefined -> full-chain wrap-around.
//
// Ports:
//   clk     in               rising-edge clock
//   clr     in               synchronous active-low reset (Q=0, ovf=0)
//   enable  in               count/load qualifier
//   load    in               parallel load request (only with enable=1)
//   up      in               1 = count up, 0 = count down
//   D       in  DIGITS*DW    load value, digit i = D[i*DW +: DW]
//   Q       out DIGITS*DW    registered count, same packing as D
//   Co      out              combinational terminal count for cascading
//   ovf     out              registered sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module bcd_updown_counter_chain
    import bcd_counter_pkg::*;
#(
    parameter int  DIGITS = 2,
    parameter int  MOD    = 10,
    localparam int DW     = digit_width(MOD)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 enable,
    input  logic                 load,
    input  logic                 up,
    input  logic [DIGITS*DW-1:0] D,
    output logic [DIGITS*DW-1:0] Q,
    output logic                 Co,
    output logic                 ovf
);

    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] lower_term;  // all digits below i are terminal
    logic [DIGITS-1:0] step;
    logic              all_term;
    logic              count_en;
    logic              load_en;
    logic              ovf_q;
    logic              ovf_d;

    assign load_en  = enable & load;
    assign count_en = enable & ~load;

    // Ripple-enable chain, evaluated as a prefix AND of the digit terms.
    always_comb begin
        logic lower;
        lower      = 1'b1;
        lower_term = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lower_term[i] = lower;
            lower         = lower & term[i];
        end
        all_term = lower;
    end

    assign Co = enable & all_term;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_CHAIN_SATURATE_EN
            // At the chain's terminal count nothing moves: saturate.
            step[i] = count_en & lower_term[i] & ~all_term;
`else
            step[i] = count_en & lower_term[i];
`endif
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mod_digit_cell #(
            .MOD (MOD),
            .DW  (DW)
        ) u_cell (
            .clk  (clk),
            .clr  (clr),
            .step (step[g]),
            .load (load_en),
            .up   (up),
            .d    (D[g*DW +: DW]),
            .q    (Q[g*DW +: DW]),
            .term (term[g])
        );
    end

    // Sticky flag: set by a counting edge at the terminal count, cleared by
    // load (here) or by clr (in the register).
    always_comb begin
        ovf_d = ovf_q;
        if (load_en) begin
            ovf_d = 1'b0;
        end else if (count_en && all_term) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule
